mem_word_xfer: RTL

Parametrised byte-serial transfer engine between a DATA_W-bit datapath word and the byte-wide Memory. It replaces manual high/low byte steering (MuxC-style output selection, IR LH-style loading) with a sequenced multi-beat read or write. It has a Start/Busy/Done handshake, auto-incrementing addresses and a fixed byte order. It sits between the ALU-system datapath (ALUOut / mux inputs) and the Memory port.

---
 rtl/mem_xfer_pkg.sv | 22 ++
 rtl/xfer_beat_ctr.sv | 38 +++
 rtl/mem_word_xfer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_xfer_pkg.sv
// Shared state encoding and lane helpers for the byte-serial word transfer engine.
package mem_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    TAIL = 2'd2
  } xfer_state_e;

  function automatic int beats_of(input int data_w);
    return data_w / 8;
  endfunction

  // Bit offset of the byte carried by a given beat; out-of-range beats map to lane 0.
  function automatic int unsigned lane_lsb(input int unsigned beat,
                                           input int unsigned beats,
                                           input bit          big_endian);
    if (beat >= beats) return 0;
    return big_endian ? 8 * (beats - 1 - beat) : 8 * beat;
  endfunction

endpackage

// File: rtl/xfer_beat_ctr.sv
// Beat index, auto-incrementing memory address and last-beat detect for mem_word_xfer.
module xfer_beat_ctr #(
  parameter int ADDR_W = 16,
  parameter int BEATS  = 2,
  parameter int BW     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] addr,
  output logic [BW-1:0]     beat,
  output logic              last
);

  logic [BW-1:0] remain;

  // Remaining-beats down-counter gives the terminal count; beat is the lane index.
  assign last = (remain == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr   <= '0;
      beat   <= '0;
      remain <= '0;
    end else if (load) begin
      addr   <= base_addr;
      beat   <= '0;
      remain <= BW'(BEATS - 1);
    end else if (advance && !last) begin
      addr   <= addr + 1'b1;
      beat   <= beat + 1'b1;
      remain <= remain - 1'b1;
    end
  end

endmodule

// File: rtl/mem_word_xfer.sv
// Byte-serial word transfer engine between a DATA_W datapath word and byte-wide memory.
// Build option: define XFER_BIG_ENDIAN_EN to put the most significant byte at base_addr.
//
// state | meaning
// IDLE  | waiting for start; memory deselected
// XFER  | one memory beat per cycle, address auto-increments
// TAIL  | read only: last byte arrives, word_out loaded, done follows
module mem_word_xfer
  import mem_xfer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] word_in,
  output logic [DATA_W-1:0] word_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_data,
  output logic              mem_wr,
  output logic              mem_cs,
  input  logic [7:0]        mem_in
);

  localparam int BEATS = beats_of(DATA_W);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

`ifdef XFER_BIG_ENDIAN_EN
  localparam bit BIG_END = 1'b1;
`else
  localparam bit BIG_END = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_XFER = XFER;
  localparam logic [1:0] ST_TAIL = TAIL;

  logic [1:0]        state;
  logic              dir_q;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] asm_next;
  logic [DATA_W-1:0] lane_mask;
  logic [BW-1:0]     beat;
  logic [BW-1:0]     beat_nx;
  logic              last_beat;
  logic              cap_valid;
  logic [BW-1:0]     cap_idx;
  logic              accept;
  logic              advance;

  function automatic logic [7:0] lane_byte(input logic [DATA_W-1:0] w,
                                           input logic [BW-1:0]     b);
    return 8'(w >> lane_lsb(32'(b), BEATS, BIG_END));
  endfunction

  assign accept  = (state == ST_IDLE) && start;
  assign advance = (state == ST_XFER);
  assign beat_nx = beat + 1'b1;

  xfer_beat_ctr #(
    .ADDR_W (ADDR_W),
    .BEATS  (BEATS),
    .BW     (BW)
  ) u_beat_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .advance   (advance),
    .base_addr (base_addr),
    .addr      (mem_address),
    .beat      (beat),
    .last      (last_beat)
  );

  // Read byte for beat cap_idx arrives one cycle after its address was issued.
  always_comb begin
    lane_mask = DATA_W'(8'hFF) << lane_lsb(32'(cap_idx), BEATS, BIG_END);
    asm_next  = (asm_q & ~lane_mask) |
                (DATA_W'(mem_in) << lane_lsb(32'(cap_idx), BEATS, BIG_END));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dir_q     <= 1'b0;
      word_q    <= '0;
      asm_q     <= '0;
      word_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_data  <= 8'h00;
      mem_wr    <= 1'b0;
      mem_cs    <= 1'b1;
      cap_valid <= 1'b0;
      cap_idx   <= '0;
    end else begin
      done      <= 1'b0;
      cap_valid <= advance && !dir_q;
      cap_idx   <= beat;
      if (cap_valid) asm_q <= asm_next;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_XFER;
            dir_q    <= dir;
            word_q   <= word_in;
            busy     <= 1'b1;
            mem_cs   <= 1'b0;
            mem_wr   <= dir;
            mem_data <= dir ? lane_byte(word_in, '0) : 8'h00;
          end
        end
        ST_XFER: begin
          if (last_beat) begin
            mem_cs   <= 1'b1;
            mem_wr   <= 1'b0;
            mem_data <= 8'h00;
            if (dir_q) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_TAIL;
            end
          end else if (dir_q) begin
            mem_data <= lane_byte(word_q, beat_nx);
          end
        end
        ST_TAIL: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          word_out <= asm_next;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
